// File: rtl/irq_priority_sequencer.sv
// 27-channel (3 buses x 9) edge-latched interrupt sequencer: fixed priority A>B>C, low channel first,
// valid/ack handshake with post-ack holdoff. Optional grant abandon timer under IRQ_TIMEOUT_EN.
module irq_priority_sequencer #(
  parameter int HOLDOFF_CYC = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] req_a,
  input  logic [8:0] req_b,
  input  logic [8:0] req_c,
  input  logic [8:0] en_a,
  input  logic [8:0] en_b,
  input  logic [8:0] en_c,
  input  logic       irq_ack,
  output logic       irq_valid,
  output logic [1:0] irq_bus,
  output logic [3:0] irq_chan,
  output logic       pend_any,
  output logic       irq_timeout
);
  localparam int NB = 3;
  localparam int NC = 9;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLDOFF} state_t;

  // Out-of-range parameters elaborate this empty marker block, easy to spot in the hierarchy.
  if (HOLDOFF_CYC < 1 || HOLDOFF_CYC > 15 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_param_range_bad
  end

  state_t                r_state;
  logic [3:0]            r_hcnt;
  logic [NB-1:0][NC-1:0] r_req_q, r_pend;
  logic [NB-1:0][NC-1:0] w_req, w_en, w_set, w_clr, w_pend_nxt, w_cand;
  logic                  w_ack, w_hit;
  logic [1:0]            w_win_bus;
  logic [3:0]            w_win_chan;

  assign w_req      = {req_c, req_b, req_a};
  assign w_en       = {en_c, en_b, en_a};
  assign w_set      = w_req & ~r_req_q;
  assign w_ack      = (r_state == S_GRANT) && irq_ack;
  assign w_pend_nxt = (r_pend & ~w_clr) | w_set;
  assign w_cand     = r_pend & w_en;

  always_comb begin
    w_clr = '0;
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NC; c++)
        w_clr[b][c] = w_ack && (irq_bus == 2'(b)) && (irq_chan == 4'(c));
  end

  // Scan from lowest priority upward so the last hit is the winner.
  always_comb begin
    w_hit      = 1'b0;
    w_win_bus  = '0;
    w_win_chan = '0;
    for (int b = NB - 1; b >= 0; b--)
      for (int c = NC - 1; c >= 0; c--)
        if (w_cand[b][c]) begin
          w_hit      = 1'b1;
          w_win_bus  = 2'(b);
          w_win_chan = 4'(c);
        end
  end

`ifdef IRQ_TIMEOUT_EN
  logic [7:0] r_tcnt;
  logic       r_timeout;
  assign irq_timeout = r_timeout;
`else
  assign irq_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hcnt    <= '0;
      r_req_q   <= '0;
      r_pend    <= '0;
      irq_valid <= 1'b0;
      irq_bus   <= '0;
      irq_chan  <= '0;
      pend_any  <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_req_q  <= w_req;
      r_pend   <= w_pend_nxt;
      pend_any <= |(w_pend_nxt & w_en);
`ifdef IRQ_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_GRANT: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            r_hcnt    <= 4'(HOLDOFF_CYC - 1);
            r_state   <= S_HOLDOFF;
          end
`ifdef IRQ_TIMEOUT_EN
          else if (r_tcnt == 8'(TIMEOUT_CYC - 1)) begin
            // Abandon without clearing pending: the channel is offered again later.
            irq_valid <= 1'b0;
            r_timeout <= 1'b1;
            r_hcnt    <= 4'(HOLDOFF_CYC - 1);
            r_state   <= S_HOLDOFF;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
`endif
        end
        default: begin
          // Holdoff expiry arbitrates directly so the dead time is exactly HOLDOFF_CYC cycles.
          if (r_state == S_HOLDOFF && r_hcnt != 4'd0) begin
            r_hcnt <= r_hcnt - 4'd1;
          end else if (w_hit) begin
            irq_valid <= 1'b1;
            irq_bus   <= w_win_bus;
            irq_chan  <= w_win_chan;
            r_state   <= S_GRANT;
`ifdef IRQ_TIMEOUT_EN
            r_tcnt    <= '0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_priority_sequencer.sv
// Scoreboard bench for irq_priority_sequencer; expected grants are queued when requests are driven.
module tb_irq_priority_sequencer;
`ifdef IRQ_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif
  localparam int HO = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] req_a, req_b, req_c, en_a, en_b, en_c;
  logic       irq_ack, irq_valid, pend_any, irq_timeout;
  logic [1:0] irq_bus;
  logic [3:0] irq_chan;

  typedef struct {
    logic [1:0] bus;
    logic [3:0] chan;
  } gnt_t;
  gnt_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_to  = 0;

  irq_priority_sequencer #(.HOLDOFF_CYC(HO), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .en_a(en_a), .en_b(en_b), .en_c(en_c),
    .irq_ack(irq_ack), .irq_valid(irq_valid), .irq_bus(irq_bus),
    .irq_chan(irq_chan), .pend_any(pend_any), .irq_timeout(irq_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (irq_timeout === 1'b1) n_to++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [1:0] b, input logic [3:0] c);
    gnt_t g;
    g.bus = b; g.chan = c;
    sb.push_back(g);
  endtask

  // Wait (bounded) for a grant, then compare it against the oldest queued expectation.
  task automatic serve(input string tag, output int w);
    gnt_t e;
    w = 0;
    while (irq_valid !== 1'b1 && w < 30) begin step(1); w++; end
    if (irq_valid !== 1'b1) begin chk({tag, "_wait"}, 0, 1); return; end
    if (sb.size() == 0) begin chk({tag, "_sb"}, 0, 1); return; end
    e = sb.pop_front();
    chk({tag, "_bus"}, 32'(irq_bus), 32'(e.bus));
    chk({tag, "_chan"}, 32'(irq_chan), 32'(e.chan));
  endtask

  task automatic ack(input string tag);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk({tag, "_drop"}, 32'(irq_valid), 0);
  endtask

  initial begin
    int w, seen;
    rst = 1'b1; irq_ack = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    en_a = '1; en_b = '1; en_c = '1;
    step(2);
    rst = 1'b0;
    chk("rst_valid", 32'(irq_valid), 0);
    chk("rst_bus", 32'(irq_bus), 0);
    chk("rst_chan", 32'(irq_chan), 0);
    chk("rst_pend", 32'(pend_any), 0);
    chk("rst_to", 32'(irq_timeout), 0);
    step(1);

    // Single request with exact latency; ack while IDLE is ignored.
    req_a[3] = 1'b1; irq_ack = 1'b1; push(2'd0, 4'd3);
    step(1);
    chk("single_lat1_valid", 32'(irq_valid), 0);
    chk("single_lat1_pend", 32'(pend_any), 1);
    step(1);
    irq_ack = 1'b0;
    chk("single_lat2_valid", 32'(irq_valid), 1);
    serve("single", w);
    chk("single_w", 32'(w), 0);
    ack("single");
    chk("single_pend_clr", 32'(pend_any), 0);
    step(3);
    chk("single_idle", 32'(irq_valid), 0);

    // Fixed priority across buses, with holdoff gaps; held-high req_a[3] must not re-arm.
    req_c[0] = 1'b1; req_b[8] = 1'b1; req_a[7] = 1'b1;
    push(2'd0, 4'd7); push(2'd1, 4'd8); push(2'd2, 4'd0);
    serve("prio0", w);
    chk("prio0_w", 32'(w), 2);
    ack("prio0");
    serve("prio1", w);
    chk("prio1_gap", 32'(w), HO);
    ack("prio1");
    serve("prio2", w);
    chk("prio2_gap", 32'(w), HO);
    ack("prio2");
    req_a = '0; req_b = '0; req_c = '0;
    step(6);
    chk("prio_empty", 32'(pend_any), 0);

    // Masked channel latches but is not selected until enabled.
    en_b[2] = 1'b0; req_b[2] = 1'b1;
    step(4);
    chk("mask_valid", 32'(irq_valid), 0);
    chk("mask_pend", 32'(pend_any), 0);
    en_b[2] = 1'b1; push(2'd1, 4'd2);
    serve("mask", w);
    chk("mask_lat_ok", 32'(w <= 2), 1);
    ack("mask");
    req_b[2] = 1'b0;
    step(4);

    // Grant stability, then set-wins on the ack cycle of the granted channel.
    req_a[5] = 1'b1; push(2'd0, 4'd5);
    serve("stab", w);
    req_a[0] = 1'b1; req_a[5] = 1'b0; en_a[5] = 1'b0;
    step(2);
    chk("stab_valid", 32'(irq_valid), 1);
    chk("stab_chan", 32'(irq_chan), 5);
    chk("stab_bus", 32'(irq_bus), 0);
    en_a[5] = 1'b1; req_a[5] = 1'b1;
    push(2'd0, 4'd0); push(2'd0, 4'd5);
    ack("stab");
    serve("setwin0", w);
    chk("setwin0_gap", 32'(w), HO);
    ack("setwin0");
    serve("setwin1", w);
    chk("setwin1_gap", 32'(w), HO);
    ack("setwin1");
    req_a = '0;
    step(4);
    chk("setwin_empty", 32'(pend_any), 0);

`ifdef IRQ_TIMEOUT_EN
    // Unacked grant is abandoned after TO cycles and offered again after holdoff.
    req_c[6] = 1'b1; push(2'd2, 4'd6);
    serve("to", w);
    w = 0;
    while (irq_valid === 1'b1 && w < 20) begin step(1); w++; end
    chk("to_len", 32'(w), TO);
    chk("to_pulse", 32'(irq_timeout), 1);
    step(1);
    chk("to_pulse_end", 32'(irq_timeout), 0);
    push(2'd2, 4'd6);
    serve("to_regrant", w);
    chk("to_regrant_gap", 32'(w), HO - 1);
    ack("to_regrant");
    req_c = '0;
    step(2);
    chk("to_count", 32'(n_to), 1);
`else
    // Without the timer a grant waits indefinitely.
    req_c[6] = 1'b1; push(2'd2, 4'd6);
    serve("hold", w);
    step(70);
    chk("hold_valid", 32'(irq_valid), 1);
    chk("hold_chan", 32'(irq_chan), 6);
    ack("hold");
    req_c = '0;
    step(2);
    chk("to_count", 32'(n_to), 0);
`endif

    // Reset while granting discards everything; no grant follows.
    step(4);
    req_b[4] = 1'b1; req_c[1] = 1'b1;
    step(2);
    chk("rstmid_grant", 32'(irq_valid), 1);
    rst = 1'b1; req_b = '0; req_c = '0;
    step(1);
    rst = 1'b0;
    chk("rstmid_valid", 32'(irq_valid), 0);
    chk("rstmid_pend", 32'(pend_any), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (irq_valid !== 1'b0 || pend_any !== 1'b0) seen = 1;
    end
    chk("rstmid_quiet", 32'(seen), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
